// File: rtl/asi_pkg.sv
// Shared AXI definitions for the read/write 4KB burst splitters.
package asi_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2
   } state_e;

   localparam int BOUND_4K = 4096;

endpackage

// File: rtl/axi_4k_calc.sv
// Combinational sub-burst sizing: how many beats fit before the next 4KB
// boundary, the resulting ARLEN, the following aligned address and what is left.
module axi_4k_calc
   import asi_pkg::*;
#(
   parameter int AW = 32,
   parameter int LW = 8,
   parameter int SW = 3
) (
   input  logic [AW-1:0] addr,
   input  logic [SW-1:0] size,
   input  logic [LW:0]   rem,
   output logic [LW-1:0] arlen,
   output logic [AW-1:0] next_addr,
   output logic [LW:0]   rem_next
);

   logic [AW-1:0] low_mask;
   logic [AW-1:0] aligned;
   logic [12:0]   to_bnd;
   logic [LW:0]   n;

   assign low_mask = ~({AW{1'b1}} << size);
   assign aligned  = addr & ~low_mask;
   // 13 bits so a page-aligned start yields the full 4096-byte window
   assign to_bnd   = (13'(BOUND_4K) - {1'b0, aligned[11:0]}) >> size;

   always_comb begin
      n = rem;
      if (13'(rem) > to_bnd) begin
         n = to_bnd[LW:0];
      end
   end

   assign arlen     = LW'(n - (LW+1)'(1));
   assign rem_next  = rem - n;
   assign next_addr = {aligned[AW-1:12] + (AW-12)'(1), 12'h000};

endmodule

// File: rtl/axi_rd_4k_split.sv
// AXI4 read burst splitter: breaks INCR bursts at 4KB boundaries, merges R beats.
// Optional saturating split counter enabled by defining AXI_RD_SPLIT_CNT_EN.
module axi_rd_4k_split
   import asi_pkg::*;
#(
   parameter int AXI_DW     = 128,
   parameter int AXI_AW     = 32,
   parameter int AXI_IW     = 8,
   parameter int AXI_LW     = 8,
   parameter int AXI_SW     = 3,
   parameter int AXI_BURSTW = 2,
   parameter int AXI_RRESPW = 2
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [AXI_IW-1:0]     S_ARID,
   input  logic [AXI_AW-1:0]     S_ARADDR,
   input  logic [AXI_LW-1:0]     S_ARLEN,
   input  logic [AXI_SW-1:0]     S_ARSIZE,
   input  logic [AXI_BURSTW-1:0] S_ARBURST,
   input  logic                  S_ARVALID,
   output logic                  S_ARREADY,
   output logic [AXI_IW-1:0]     S_RID,
   output logic [AXI_DW-1:0]     S_RDATA,
   output logic [AXI_RRESPW-1:0] S_RRESP,
   output logic                  S_RLAST,
   output logic                  S_RVALID,
   input  logic                  S_RREADY,
   output logic [AXI_IW-1:0]     M_ARID,
   output logic [AXI_AW-1:0]     M_ARADDR,
   output logic [AXI_LW-1:0]     M_ARLEN,
   output logic [AXI_SW-1:0]     M_ARSIZE,
   output logic [AXI_BURSTW-1:0] M_ARBURST,
   output logic                  M_ARVALID,
   input  logic                  M_ARREADY,
   input  logic [AXI_IW-1:0]     M_RID,
   input  logic [AXI_DW-1:0]     M_RDATA,
   input  logic [AXI_RRESPW-1:0] M_RRESP,
   input  logic                  M_RLAST,
   input  logic                  M_RVALID,
   output logic                  M_RREADY
`ifdef AXI_RD_SPLIT_CNT_EN
   ,
   input  logic                  split_cnt_clr,
   output logic [15:0]           split_cnt
`endif
);

   state_e                  state_reg, state_next;
   logic [AXI_IW-1:0]       m_arid_reg;
   logic [AXI_AW-1:0]       m_araddr_reg;
   logic [AXI_LW-1:0]       m_arlen_reg;
   logic [AXI_SW-1:0]       m_arsize_reg;
   logic [AXI_BURSTW-1:0]   m_arburst_reg;
   logic [AXI_AW-1:0]       next_addr_reg;
   logic [AXI_LW:0]         rem_reg;

   logic [AXI_AW-1:0]       calc_addr;
   logic [AXI_SW-1:0]       calc_size;
   logic [AXI_LW:0]         calc_rem;
   logic [AXI_LW-1:0]       calc_arlen;
   logic [AXI_AW-1:0]       calc_next_addr;
   logic [AXI_LW:0]         calc_rem_next;

   logic cap_fire;
   logic cap_incr;
   logic ar_fire;
   logic last_fire;
   logic last_sub;

   assign cap_fire  = (state_reg == IDLE) && S_ARVALID;
   assign cap_incr  = (S_ARBURST == AXI_BURSTW'(INCR));
   assign ar_fire   = (state_reg == ISSUE) && M_ARREADY;
   assign last_fire = (state_reg == DATA) && M_RVALID && S_RREADY && M_RLAST;
   assign last_sub  = (rem_reg == '0);

   // Idle sizes the incoming request; otherwise it sizes the follow-on sub-burst
   always_comb begin
      calc_addr = next_addr_reg;
      calc_size = m_arsize_reg;
      calc_rem  = rem_reg;
      if (state_reg == IDLE) begin
         calc_addr = S_ARADDR;
         calc_size = S_ARSIZE;
         calc_rem  = {1'b0, S_ARLEN} + (AXI_LW+1)'(1);
      end
   end

   axi_4k_calc #(
      .AW (AXI_AW),
      .LW (AXI_LW),
      .SW (AXI_SW)
   ) u_calc (
      .addr      (calc_addr),
      .size      (calc_size),
      .rem       (calc_rem),
      .arlen     (calc_arlen),
      .next_addr (calc_next_addr),
      .rem_next  (calc_rem_next)
   );

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cap_fire) state_next = ISSUE;
         ISSUE:   if (ar_fire) state_next = DATA;
         DATA:    if (last_fire) state_next = last_sub ? IDLE : ISSUE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      S_ARREADY = 1'b0;
      M_ARVALID = 1'b0;
      S_RVALID  = 1'b0;
      M_RREADY  = 1'b0;
      S_RLAST   = 1'b0;
      case (state_reg)
         IDLE:  S_ARREADY = 1'b1;
         ISSUE: M_ARVALID = 1'b1;
         DATA: begin
            S_RVALID = M_RVALID;
            M_RREADY = S_RREADY;
            S_RLAST  = M_RLAST & last_sub;
         end
         default: ;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         m_arid_reg    <= '0;
         m_araddr_reg  <= '0;
         m_arlen_reg   <= '0;
         m_arsize_reg  <= '0;
         m_arburst_reg <= '0;
         next_addr_reg <= '0;
         rem_reg       <= '0;
      end else if (cap_fire) begin
         m_arid_reg    <= S_ARID;
         m_araddr_reg  <= S_ARADDR;
         m_arsize_reg  <= S_ARSIZE;
         m_arburst_reg <= S_ARBURST;
         next_addr_reg <= calc_next_addr;
         // FIXED and WRAP bursts go out untouched as a single request
         if (cap_incr) begin
            m_arlen_reg <= calc_arlen;
            rem_reg     <= calc_rem_next;
         end else begin
            m_arlen_reg <= S_ARLEN;
            rem_reg     <= '0;
         end
      end else if (last_fire && !last_sub) begin
         m_araddr_reg  <= next_addr_reg;
         m_arlen_reg   <= calc_arlen;
         rem_reg       <= calc_rem_next;
         next_addr_reg <= calc_next_addr;
      end
   end

   assign M_ARID    = m_arid_reg;
   assign M_ARADDR  = m_araddr_reg;
   assign M_ARLEN   = m_arlen_reg;
   assign M_ARSIZE  = m_arsize_reg;
   assign M_ARBURST = m_arburst_reg;

   assign S_RID   = M_RID;
   assign S_RDATA = M_RDATA;
   assign S_RRESP = M_RRESP;

`ifdef AXI_RD_SPLIT_CNT_EN
   logic [15:0] split_cnt_reg;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         split_cnt_reg <= '0;
      end else if (split_cnt_clr) begin
         split_cnt_reg <= '0;
      end else if (cap_fire && cap_incr && (calc_rem_next != '0) &&
                   (split_cnt_reg != 16'hFFFF)) begin
         split_cnt_reg <= split_cnt_reg + 16'd1;
      end
   end

   assign split_cnt = split_cnt_reg;
`endif

endmodule

// File: tb/tb_axi_rd_4k_split.sv
// Directed bench for axi_rd_4k_split: split/pass-through cases, throttling, mid-burst reset.
module tb_axi_rd_4k_split;

   logic         ACLK = 1'b0;
   logic         ARESETn;
   logic [7:0]   S_ARID;
   logic [31:0]  S_ARADDR;
   logic [7:0]   S_ARLEN;
   logic [2:0]   S_ARSIZE;
   logic [1:0]   S_ARBURST;
   logic         S_ARVALID;
   logic         S_ARREADY;
   logic [7:0]   S_RID;
   logic [127:0] S_RDATA;
   logic [1:0]   S_RRESP;
   logic         S_RLAST;
   logic         S_RVALID;
   logic         S_RREADY;
   logic [7:0]   M_ARID;
   logic [31:0]  M_ARADDR;
   logic [7:0]   M_ARLEN;
   logic [2:0]   M_ARSIZE;
   logic [1:0]   M_ARBURST;
   logic         M_ARVALID;
   logic         M_ARREADY;
   logic [7:0]   M_RID;
   logic [127:0] M_RDATA;
   logic [1:0]   M_RRESP;
   logic         M_RLAST;
   logic         M_RVALID;
   logic         M_RREADY;

   always #5 ACLK = ~ACLK;

   axi_rd_4k_split dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .S_ARID    (S_ARID),
      .S_ARADDR  (S_ARADDR),
      .S_ARLEN   (S_ARLEN),
      .S_ARSIZE  (S_ARSIZE),
      .S_ARBURST (S_ARBURST),
      .S_ARVALID (S_ARVALID),
      .S_ARREADY (S_ARREADY),
      .S_RID     (S_RID),
      .S_RDATA   (S_RDATA),
      .S_RRESP   (S_RRESP),
      .S_RLAST   (S_RLAST),
      .S_RVALID  (S_RVALID),
      .S_RREADY  (S_RREADY),
      .M_ARID    (M_ARID),
      .M_ARADDR  (M_ARADDR),
      .M_ARLEN   (M_ARLEN),
      .M_ARSIZE  (M_ARSIZE),
      .M_ARBURST (M_ARBURST),
      .M_ARVALID (M_ARVALID),
      .M_ARREADY (M_ARREADY),
      .M_RID     (M_RID),
      .M_RDATA   (M_RDATA),
      .M_RRESP   (M_RRESP),
      .M_RLAST   (M_RLAST),
      .M_RVALID  (M_RVALID),
      .M_RREADY  (M_RREADY)
   );

   int total = 0;
   int bad   = 0;

   // What the bench observed during the most recent burst
   int           obs_nsub;
   logic [31:0]  obs_addr  [4];
   logic [7:0]   obs_len   [4];
   logic [7:0]   obs_id    [4];
   logic [2:0]   obs_size  [4];
   logic [1:0]   obs_burst [4];
   int           obs_wait  [4];
   int           obs_beats;
   logic [127:0] obs_data  [256];
   logic [1:0]   obs_resp  [256];
   logic [7:0]   obs_rid   [256];
   int           obs_nlast;
   int           obs_last_pos;
   int           obs_unstable;
   int           obs_busy_ready;
   bit           obs_timeout;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          nsub;
      logic [31:0] a0;
      logic [7:0]  l0;
      logic [31:0] a1;
      logic [7:0]  l1;
   } vec_t;

   vec_t vecs [5];

   function automatic logic [127:0] beat_data(input int i);
      return {4{32'hA500_0000 + 32'(i)}};
   endfunction

   // Acts as master and slave for one burst; stop_after cuts it short after that many R beats
   task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int ar_hold,
                           input bit rthrottle, input int stop_after);
      int total_beats, sent, guard, n, b;
      obs_nsub = 0; obs_beats = 0; obs_nlast = 0; obs_last_pos = -1;
      obs_unstable = 0; obs_busy_ready = 0; obs_timeout = 1'b0;
      total_beats = int'(len) + 1;
      sent = 0;
      S_RREADY = 1'b1;
      @(negedge ACLK);
      S_ARID = id; S_ARADDR = addr; S_ARLEN = len; S_ARSIZE = size; S_ARBURST = burst;
      S_ARVALID = 1'b1;
      #1;
      guard = 0;
      while (!S_ARREADY && guard < 50) begin
         @(negedge ACLK); #1; guard++;
      end
      if (!S_ARREADY) begin
         obs_timeout = 1'b1; S_ARVALID = 1'b0;
         return;
      end
      @(posedge ACLK); #1;
      S_ARVALID = 1'b0;
      S_ARID = 8'hEE; S_ARADDR = 32'hDEAD_BEEF; S_ARLEN = 8'hCC; S_ARSIZE = 3'd7; S_ARBURST = 2'b11;
      while (sent < total_beats && obs_nsub < 4) begin
         @(negedge ACLK); #1;
         guard = 0;
         while (!M_ARVALID && guard < 50) begin
            if (S_ARREADY) obs_busy_ready++;
            @(negedge ACLK); #1; guard++;
         end
         if (!M_ARVALID) begin
            obs_timeout = 1'b1;
            return;
         end
         if (S_ARREADY) obs_busy_ready++;
         obs_wait[obs_nsub]  = guard;
         obs_addr[obs_nsub]  = M_ARADDR;
         obs_len[obs_nsub]   = M_ARLEN;
         obs_id[obs_nsub]    = M_ARID;
         obs_size[obs_nsub]  = M_ARSIZE;
         obs_burst[obs_nsub] = M_ARBURST;
         for (int h = 0; h < ar_hold; h++) begin
            @(negedge ACLK); #1;
            if (!M_ARVALID || M_ARADDR !== obs_addr[obs_nsub] || M_ARLEN !== obs_len[obs_nsub])
               obs_unstable++;
         end
         @(negedge ACLK);
         M_ARREADY = 1'b1;
         @(posedge ACLK); #1;
         M_ARREADY = 1'b0;
         n = int'(obs_len[obs_nsub]) + 1;
         obs_nsub++;
         b = 0; guard = 0;
         while (b < n && guard < 2000) begin
            @(negedge ACLK);
            M_RVALID = 1'b1; M_RDATA = beat_data(sent); M_RID = id;
            M_RRESP = 2'(sent % 4); M_RLAST = (b == n - 1);
            S_RREADY = rthrottle ? ~S_RREADY : 1'b1;
            #1;
            if (S_ARREADY) obs_busy_ready++;
            if (S_RVALID && S_RREADY) begin
               if (!M_RREADY) obs_unstable++;
               obs_data[sent] = S_RDATA;
               obs_resp[sent] = S_RRESP;
               obs_rid[sent]  = S_RID;
               if (S_RLAST) begin
                  obs_nlast++; obs_last_pos = sent;
               end
               @(posedge ACLK);
               b++; sent++; obs_beats++;
               if (sent == stop_after) begin
                  #1; M_RVALID = 1'b0; M_RLAST = 1'b0;
                  return;
               end
            end
            guard++;
         end
         #1; M_RVALID = 1'b0; M_RLAST = 1'b0;
         if (b < n) begin
            obs_timeout = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      ARESETn = 1'b0;
      M_RVALID = 1'b1;
      #2;
      total++;
      if (S_ARREADY !== 1'b1) begin
         bad++; $display("FAIL reset_arready got=%b exp=1", S_ARREADY);
      end
      total++;
      if (M_ARVALID !== 1'b0 || M_ARADDR !== 32'h0 || M_ARLEN !== 8'h0 || M_ARID !== 8'h0) begin
         bad++; $display("FAIL reset_mar got valid=%b addr=%h len=%h id=%h exp all zero",
                         M_ARVALID, M_ARADDR, M_ARLEN, M_ARID);
      end
      total++;
      if (S_RVALID !== 1'b0) begin
         bad++; $display("FAIL reset_rvalid got=%b exp=0", S_RVALID);
      end
      M_RVALID = 1'b0;
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK); #1;
      total++;
      if (S_ARREADY !== 1'b1 || M_ARVALID !== 1'b0) begin
         bad++; $display("FAIL post_reset got arready=%b arvalid=%b exp 1/0", S_ARREADY, M_ARVALID);
      end
   endtask

   task automatic test_split_cases();
      int errs;
      vecs[0] = '{32'h0000_0FF0, 8'd7,   3'd2, 2'b01, 2, 32'h0000_0FF0, 8'd3,   32'h0000_1000, 8'd3};
      vecs[1] = '{32'h0000_0FFE, 8'd1,   3'd2, 2'b01, 2, 32'h0000_0FFE, 8'd0,   32'h0000_1000, 8'd0};
      vecs[2] = '{32'h0000_0800, 8'd255, 3'd4, 2'b01, 2, 32'h0000_0800, 8'd127, 32'h0000_1000, 8'd127};
      vecs[3] = '{32'h0000_0000, 8'd15,  3'd4, 2'b01, 1, 32'h0000_0000, 8'd15,  32'h0,         8'd0};
      vecs[4] = '{32'h1234_5F80, 8'd31,  3'd3, 2'b01, 2, 32'h1234_5F80, 8'd15,  32'h1234_6000, 8'd15};
      for (int v = 0; v < 5; v++) begin
         do_burst(8'h10 + 8'(v), vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 0, 1'b0, 1000);
         total++;
         if (obs_timeout) begin
            bad++; $display("FAIL split%0d_timeout got=1 exp=0", v);
         end
         total++;
         if (obs_nsub !== vecs[v].nsub) begin
            bad++; $display("FAIL split%0d_nsub got=%0d exp=%0d", v, obs_nsub, vecs[v].nsub);
         end
         total++;
         if (obs_addr[0] !== vecs[v].a0 || obs_len[0] !== vecs[v].l0) begin
            bad++; $display("FAIL split%0d_sub0 got=%h/%0d exp=%h/%0d", v, obs_addr[0], obs_len[0],
                            vecs[v].a0, vecs[v].l0);
         end
         if (vecs[v].nsub == 2) begin
            total++;
            if (obs_addr[1] !== vecs[v].a1 || obs_len[1] !== vecs[v].l1) begin
               bad++; $display("FAIL split%0d_sub1 got=%h/%0d exp=%h/%0d", v, obs_addr[1], obs_len[1],
                               vecs[v].a1, vecs[v].l1);
            end
         end
         errs = 0;
         for (int s = 0; s < obs_nsub; s++) begin
            if (obs_id[s] !== 8'h10 + 8'(v) || obs_size[s] !== vecs[v].size ||
                obs_burst[s] !== vecs[v].burst || obs_wait[s] !== 0) errs++;
         end
         total++;
         if (errs !== 0) begin
            bad++; $display("FAIL split%0d_ar_fields got=%0d bad subs exp=0", v, errs);
         end
         total++;
         if (obs_beats !== int'(vecs[v].len) + 1) begin
            bad++; $display("FAIL split%0d_beats got=%0d exp=%0d", v, obs_beats, int'(vecs[v].len) + 1);
         end
         total++;
         if (obs_nlast !== 1 || obs_last_pos !== int'(vecs[v].len)) begin
            bad++; $display("FAIL split%0d_rlast got count=%0d pos=%0d exp count=1 pos=%0d", v,
                            obs_nlast, obs_last_pos, vecs[v].len);
         end
         errs = 0;
         for (int i = 0; i < obs_beats; i++) begin
            if (obs_data[i] !== beat_data(i) || obs_resp[i] !== 2'(i % 4) ||
                obs_rid[i] !== 8'h10 + 8'(v)) errs++;
         end
         total++;
         if (errs !== 0) begin
            bad++; $display("FAIL split%0d_rpayload got=%0d bad beats exp=0", v, errs);
         end
         total++;
         if (obs_busy_ready !== 0 || obs_unstable !== 0) begin
            bad++; $display("FAIL split%0d_handshake got busy_arready=%0d rready_bad=%0d exp 0/0", v,
                            obs_busy_ready, obs_unstable);
         end
         @(negedge ACLK); #1;
         total++;
         if (S_ARREADY !== 1'b1 || M_ARVALID !== 1'b0) begin
            bad++; $display("FAIL split%0d_idle got arready=%b arvalid=%b exp 1/0", v, S_ARREADY, M_ARVALID);
         end
      end
   endtask

   task automatic test_wrap_throttle();
      int errs;
      do_burst(8'h5A, 32'h0000_0FF8, 8'd3, 3'd3, 2'b10, 5, 1'b1, 1000);
      total++;
      if (obs_timeout || obs_nsub !== 1) begin
         bad++; $display("FAIL wrap_nsub got=%0d timeout=%b exp=1", obs_nsub, obs_timeout);
      end
      total++;
      if (obs_addr[0] !== 32'h0000_0FF8 || obs_len[0] !== 8'd3 || obs_burst[0] !== 2'b10 ||
          obs_size[0] !== 3'd3 || obs_id[0] !== 8'h5A) begin
         bad++; $display("FAIL wrap_ar got addr=%h len=%0d burst=%b exp 00000ff8/3/10",
                         obs_addr[0], obs_len[0], obs_burst[0]);
      end
      total++;
      if (obs_unstable !== 0) begin
         bad++; $display("FAIL wrap_stable got=%0d unstable cycles exp=0", obs_unstable);
      end
      errs = 0;
      for (int i = 0; i < obs_beats; i++) begin
         if (obs_data[i] !== beat_data(i)) errs++;
      end
      total++;
      if (obs_beats !== 4 || errs !== 0 || obs_nlast !== 1 || obs_last_pos !== 3) begin
         bad++; $display("FAIL wrap_beats got beats=%0d errs=%0d last_pos=%0d exp 4/0/3",
                         obs_beats, errs, obs_last_pos);
      end
   endtask

   task automatic test_reset_mid();
      do_burst(8'h33, 32'h0000_0FF0, 8'd7, 3'd2, 2'b01, 0, 1'b0, 2);
      total++;
      if (obs_beats !== 2) begin
         bad++; $display("FAIL rmid_partial got=%0d beats exp=2", obs_beats);
      end
      @(negedge ACLK);
      M_RVALID = 1'b1; M_RLAST = 1'b0;
      ARESETn = 1'b0;
      #1;
      total++;
      if (M_ARVALID !== 1'b0 || S_ARREADY !== 1'b1 || S_RVALID !== 1'b0 || M_ARADDR !== 32'h0) begin
         bad++; $display("FAIL rmid_in_reset got arvalid=%b arready=%b rvalid=%b addr=%h exp 0/1/0/0",
                         M_ARVALID, S_ARREADY, S_RVALID, M_ARADDR);
      end
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK); #1;
      total++;
      if (S_RVALID !== 1'b0 || M_RREADY !== 1'b0 || M_ARVALID !== 1'b0) begin
         bad++; $display("FAIL rmid_after got rvalid=%b rready=%b arvalid=%b exp 0/0/0",
                         S_RVALID, M_RREADY, M_ARVALID);
      end
      M_RVALID = 1'b0;
      do_burst(8'h44, 32'h0000_0FFE, 8'd1, 3'd2, 2'b01, 0, 1'b0, 1000);
      total++;
      if (obs_timeout || obs_nsub !== 2 || obs_addr[0] !== 32'h0000_0FFE || obs_len[0] !== 8'd0 ||
          obs_addr[1] !== 32'h0000_1000 || obs_len[1] !== 8'd0) begin
         bad++; $display("FAIL rmid_next_ar got nsub=%0d a0=%h l0=%0d a1=%h l1=%0d exp 2/ffe/0/1000/0",
                         obs_nsub, obs_addr[0], obs_len[0], obs_addr[1], obs_len[1]);
      end
      total++;
      if (obs_beats !== 2 || obs_nlast !== 1 || obs_last_pos !== 1) begin
         bad++; $display("FAIL rmid_next_r got beats=%0d nlast=%0d pos=%0d exp 2/1/1",
                         obs_beats, obs_nlast, obs_last_pos);
      end
   endtask

   initial begin
      S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0; S_ARVALID = 1'b0;
      S_RREADY = 1'b1; M_ARREADY = 1'b0;
      M_RID = '0; M_RDATA = '0; M_RRESP = '0; M_RLAST = 1'b0; M_RVALID = 1'b0;
      test_reset();
      $display("reset test finished, checks so far=%0d", total);
      test_split_cases();
      $display("split cases finished, checks so far=%0d", total);
      test_wrap_throttle();
      $display("wrap throttle finished, checks so far=%0d", total);
      test_reset_mid();
      $display("mid reset finished, checks so far=%0d", total);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
